// File: rtl/jls_stream_packer_pkg.sv
// Shared constants and types for the JPEG-LS stream packer slice.
package jls_pkg;

    localparam int JLS_MAX_UNARY = 31;
    localparam int JLS_MAX_REM   = 16;
    localparam logic [7:0] JLS_MARKER_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } jls_state_e;

    // Longest codeword: unary zeros, the terminating '1', then the remainder.
    function automatic int jls_code_w(input int max_unary, input int max_rem);
        return max_unary + 1 + max_rem;
    endfunction

endpackage

// File: rtl/jls_stream_packer_if.sv
// Codeword-in / word-out boundary of the stream packer.
interface jls_stream_packer_if #(
    parameter int MAX_UNARY = 31,
    parameter int MAX_REM   = 16,
    parameter int OUT_BYTES = 4
);
    localparam int UW = $clog2(MAX_UNARY + 1);
    localparam int RW = $clog2(MAX_REM + 1);
    localparam int NW = $clog2(OUT_BYTES + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [UW-1:0]          unary_len;
    logic [RW-1:0]          rem_len;
    logic [MAX_REM-1:0]     rem_value;
    logic                   in_last;

    logic                   out_valid;
    logic                   out_ready;
    logic [8*OUT_BYTES-1:0] out_data;
    logic [NW-1:0]          out_nbytes;
    logic                   out_last;
    logic [31:0]            byte_count;

    modport master (
        output in_valid, unary_len, rem_len, rem_value, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_nbytes, out_last, byte_count
    );

    modport slave (
        input  in_valid, unary_len, rem_len, rem_value, in_last, out_ready,
        output in_ready, out_valid, out_data, out_nbytes, out_last, byte_count
    );

endinterface

// File: rtl/jls_stream_packer_word_assembler.sv
// Byte-in, word-out slot: bytes land MSB-first; a word is offered when full or tagged last.
module jls_word_assembler #(
    parameter int OUT_BYTES = 4,
    localparam int DW = 8 * OUT_BYTES,
    localparam int NW = $clog2(OUT_BYTES + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          byte_valid,
    input  logic [7:0]    byte_data,
    input  logic          byte_last,
    output logic          byte_ready,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic [NW-1:0] out_nbytes,
    output logic          out_last
);

    logic [DW-1:0] data_q, data_d;
    logic [NW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;
    logic          hs;
    logic [DW-1:0] base_data;
    logic [NW-1:0] base_cnt;
    logic          base_last;

    assign out_valid  = (cnt_q == NW'(OUT_BYTES)) || last_q;
    assign hs         = out_valid && out_ready;
    // A full slot can still take a byte in the cycle its word leaves.
    assign byte_ready = !out_valid || out_ready;
    assign out_data   = data_q;
    assign out_nbytes = cnt_q;
    assign out_last   = last_q;

    always_comb begin
        base_data = hs ? '0 : data_q;
        base_cnt  = hs ? '0 : cnt_q;
        base_last = hs ? 1'b0 : last_q;
        data_d    = base_data;
        cnt_d     = base_cnt;
        last_d    = base_last;
        if (byte_valid) begin
            data_d = base_data | ((DW'(byte_data) << (DW - 8)) >> {base_cnt, 3'b000});
            cnt_d  = base_cnt + NW'(1);
            last_d = byte_last;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
        end else begin
            data_q <= data_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/jls_stream_packer.sv
// Packs Golomb codewords MSB-first into output words with JPEG-LS 0xFF bit stuffing.
module jls_stream_packer
    import jls_pkg::*;
#(
    parameter int MAX_UNARY = JLS_MAX_UNARY,
    parameter int MAX_REM   = JLS_MAX_REM,
    parameter int OUT_BYTES = 4,
    parameter bit STUFF_EN  = 1'b1
) (
    input logic clk,
    input logic reset,
    jls_stream_packer_if.slave bus
);

    localparam int CODE_W = jls_code_w(MAX_UNARY, MAX_REM);
    localparam int ACC_W  = 2 * CODE_W;
    localparam int FW     = $clog2(ACC_W + 1);
    localparam int LW     = $clog2(CODE_W + 1);

    jls_state_e     state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [FW-1:0]  fill_q, fill_d, fill_ext;
    logic [7:0]     prev_q;
    logic [31:0]    bc_q;

    logic             acc_fire, in_ready, extract, stuff_pend, byte_final;
    logic             byte_ready, last_hs;
    logic [FW-1:0]    need;
    logic [7:0]       byte_out;
    logic [LW-1:0]    code_len;
    logic [ACC_W-1:0] rem_mask, code_val, code_left, acc_sh;

    assign acc_fire = bus.in_valid && in_ready;
    assign bus.in_ready   = in_ready;
    assign bus.byte_count = bc_q;
    assign last_hs  = bus.out_valid && bus.out_ready && bus.out_last;

    // Codeword value is '1' followed by the rem_len low bits; the leading zeros come from alignment.
    assign code_len  = LW'(bus.unary_len) + LW'(1) + LW'(bus.rem_len);
    assign rem_mask  = (ACC_W'(1) << bus.rem_len) - ACC_W'(1);
    assign code_val  = (ACC_W'(1) << bus.rem_len) | (ACC_W'(bus.rem_value) & rem_mask);
    assign code_left = code_val << (FW'(ACC_W) - FW'(code_len));

    assign stuff_pend = STUFF_EN && (prev_q == JLS_MARKER_BYTE);
    assign need       = stuff_pend ? FW'(7) : FW'(8);
    assign byte_out   = stuff_pend ? {1'b0, acc_q[ACC_W-1 -: 7]} : acc_q[ACC_W-1 -: 8];

    // Bits below fill are always zero, so a short final byte is already zero-padded.
    assign fill_ext   = extract ? ((fill_q > need) ? fill_q - need : '0) : fill_q;
    assign byte_final = (state_q == DRAIN) && (fill_ext == '0)
                        && !(STUFF_EN && (byte_out == JLS_MARKER_BYTE));

    always_comb begin
        acc_sh = acc_q;
        if (extract) acc_sh = stuff_pend ? (acc_q << 7) : (acc_q << 8);
        acc_d  = acc_sh | (acc_fire ? (code_left >> fill_ext) : '0);
        fill_d = fill_ext + (acc_fire ? FW'(code_len) : '0);
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (acc_fire && bus.in_last) state_d = DRAIN;
            DRAIN:   if (extract && byte_final)   state_d = FLUSH;
            FLUSH:   if (last_hs)                 state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        in_ready = 1'b0;
        extract  = 1'b0;
        unique case (state_q)
            RUN: begin
                in_ready = !reset && (fill_q <= FW'(ACC_W - CODE_W));
                extract  = byte_ready && (fill_q >= need);
            end
            // Keep emitting until empty, plus one 0x00 if the last byte was a marker.
            DRAIN:   extract = byte_ready && ((fill_q != '0) || stuff_pend);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            fill_q <= '0;
            prev_q <= '0;
            bc_q   <= '0;
        end else begin
            acc_q  <= acc_d;
            fill_q <= fill_d;
            if ((state_q == FLUSH) && last_hs) begin
                prev_q <= '0;
                bc_q   <= '0;
            end else if (extract) begin
                prev_q <= byte_out;
                if (bc_q != '1) bc_q <= bc_q + 32'd1;
            end
        end
    end

    jls_word_assembler #(.OUT_BYTES(OUT_BYTES)) u_word (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (extract),
        .byte_data  (byte_out),
        .byte_last  (byte_final),
        .byte_ready (byte_ready),
        .out_ready  (bus.out_ready),
        .out_valid  (bus.out_valid),
        .out_data   (bus.out_data),
        .out_nbytes (bus.out_nbytes),
        .out_last   (bus.out_last)
    );

endmodule

// File: tb/tb_jls_stream_packer.sv
// Directed bench: stuffing, flush tagging, stall back-pressure and mid-scan reset.
module tb_jls_stream_packer;

    logic        clk, reset;
    logic        in_valid, in_last, out_ready;
    logic [4:0]  unary_len, rem_len;
    logic [15:0] rem_value;

    int total = 0;
    int bad   = 0;

    jls_stream_packer_if if0 ();
    jls_stream_packer_if if1 ();

    assign if0.in_valid  = in_valid;   assign if1.in_valid  = in_valid;
    assign if0.unary_len = unary_len;  assign if1.unary_len = unary_len;
    assign if0.rem_len   = rem_len;    assign if1.rem_len   = rem_len;
    assign if0.rem_value = rem_value;  assign if1.rem_value = rem_value;
    assign if0.in_last   = in_last;    assign if1.in_last   = in_last;
    assign if0.out_ready = out_ready;  assign if1.out_ready = out_ready;

    jls_stream_packer #(.STUFF_EN(1'b1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    jls_stream_packer #(.STUFF_EN(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word monitors: inputs only change just after posedge, so a negedge handshake view is final.
    logic [7:0]  q0[$];
    int          words0 = 0, lasts0 = 0, lasts1 = 0;
    logic [31:0] ld0 = '0, lbc0 = '0, ld1 = '0;
    logic [2:0]  ln0 = '0, ln1 = '0;
    logic        ll0 = 1'b0, ll1 = 1'b0;

    always @(negedge clk) begin
        if (!reset && if0.out_valid && if0.out_ready) begin
            for (int k = 0; k < int'(if0.out_nbytes); k++) q0.push_back(if0.out_data[31-8*k -: 8]);
            words0 <= words0 + 1;
            ld0    <= if0.out_data;
            ln0    <= if0.out_nbytes;
            ll0    <= if0.out_last;
            lbc0   <= if0.byte_count;
            if (if0.out_last) lasts0 <= lasts0 + 1;
        end
        if (!reset && if1.out_valid && if1.out_ready) begin
            ld1 <= if1.out_data;
            ln1 <= if1.out_nbytes;
            ll1 <= if1.out_last;
            if (if1.out_last) lasts1 <= lasts1 + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send(input int u, input int rl, input int rv, input bit last);
        int n;
        bit ok;
        in_valid  = 1'b1;
        unary_len = 5'(u);
        rem_len   = 5'(rl);
        rem_value = 16'(rv);
        in_last   = last;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = if0.in_ready;
            n++;
        end
        chk("send_accept", 32'(ok), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_last(input int target);
        int n;
        n = 0;
        while (lasts0 < target && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("last_word_seen", 32'(lasts0 >= target), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Reference bit stream and stuffing model.
    bit         bq[$];
    logic [7:0] expq[$];

    task automatic model_code(input int u, input int rl, input int rv);
        for (int k = 0; k < u; k++) bq.push_back(1'b0);
        bq.push_back(1'b1);
        for (int k = rl - 1; k >= 0; k--) bq.push_back(((rv >> k) & 1) != 0);
    endtask

    task automatic model_bytes();
        logic [7:0] prev, b;
        int need;
        prev = 8'h00;
        while (bq.size() > 0) begin
            need = (prev == 8'hFF) ? 7 : 8;
            b = 8'h00;
            for (int k = 0; k < need; k++) b = {b[6:0], (bq.size() > 0) ? bq.pop_front() : 1'b0};
            expq.push_back(b);
            prev = b;
        end
        if (prev == 8'hFF) expq.push_back(8'h00);
    endtask

    initial begin
        int base, w0, l1;
        reset = 1'b1; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
        unary_len = '0; rem_len = '0; rem_value = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",   32'(if0.in_ready),   32'd0);
        chk("rst_out_valid",  32'(if0.out_valid),  32'd0);
        chk("rst_out_data",   if0.out_data,        32'h0);
        chk("rst_out_nbytes", 32'(if0.out_nbytes), 32'd0);
        chk("rst_out_last",   32'(if0.out_last),   32'd0);
        chk("rst_byte_count", if0.byte_count,      32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(if0.in_ready), 32'd1);
        @(posedge clk); #1;

        // FF then a 7-bit code behind the marker.
        w0 = words0;
        send(0, 7, 'h7F, 1'b0);
        send(6, 0, 0, 1'b1);
        wait_last(1);
        chk("t1_data",  ld0,         32'hFF010000);
        chk("t1_nb",    32'(ln0),    32'd2);
        chk("t1_last",  32'(ll0),    32'd1);
        chk("t1_bc",    lbc0,        32'd2);
        chk("t1_words", words0 - w0, 32'd1);

        // Exactly one full word that also carries last.
        w0 = words0;
        send(3, 4, 'hA, 1'b0);
        send(3, 4, 'hA, 1'b0);
        send(3, 4, 'hA, 1'b0);
        send(3, 4, 'hA, 1'b1);
        wait_last(2);
        chk("t2_data",  ld0,         32'h1A1A1A1A);
        chk("t2_nb",    32'(ln0),    32'd4);
        chk("t2_last",  32'(ll0),    32'd1);
        chk("t2_words", words0 - w0, 32'd1);

        // Single 1-bit code padded out.
        send(0, 0, 0, 1'b1);
        wait_last(3);
        chk("t3_data", ld0,      32'h80000000);
        chk("t3_nb",   32'(ln0), 32'd1);
        chk("t3_last", 32'(ll0), 32'd1);
        chk("t3_bc",   lbc0,     32'd1);

        // Marker at end of scan: stuffed 0x00 with STUFF_EN=1, none without.
        pulse_reset();
        l1 = lasts1;
        send(0, 7, 'h7F, 1'b1);
        wait_last(4);
        chk("t4_data",       ld0,         32'hFF000000);
        chk("t4_nb",         32'(ln0),    32'd2);
        chk("t4_bc",         lbc0,        32'd2);
        chk("t4_nostuff_n",  lasts1 - l1, 32'd1);
        chk("t4_nostuff_d",  ld1,         32'hFF000000);
        chk("t4_nostuff_nb", 32'(ln1),    32'd1);
        chk("t4_nostuff_l",  32'(ll1),    32'd1);

        // Max-length codes under a 20-cycle downstream stall.
        base = q0.size();
        bq.delete();
        expq.delete();
        out_ready = 1'b0;
        send(31, 16, 'hFFFF, 1'b0); model_code(31, 16, 'hFFFF);
        send(31, 16, 'hFFFF, 1'b0); model_code(31, 16, 'hFFFF);
        repeat (6) @(posedge clk);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall_in_ready",  32'(if0.in_ready),  32'd0);
            chk("stall_out_valid", 32'(if0.out_valid), 32'd1);
            chk("stall_out_data",  if0.out_data,       32'h00000001);
        end
        @(posedge clk); #1 out_ready = 1'b1;
        send(31, 16, 'hFFFF, 1'b0); model_code(31, 16, 'hFFFF);
        send(31, 16, 'hFFFF, 1'b0); model_code(31, 16, 'hFFFF);
        send(31, 16, 'hFFFF, 1'b0); model_code(31, 16, 'hFFFF);
        send(31, 16, 'hFFFF, 1'b1); model_code(31, 16, 'hFFFF);
        wait_last(5);
        model_bytes();
        chk("t5_nbytes_total", 32'(q0.size() - base), 32'(expq.size()));
        chk("t5_bc",           lbc0,                  32'(expq.size()));
        chk("t5_last",         32'(ll0),              32'd1);
        for (int i = 0; i < expq.size() && base + i < q0.size(); i++)
            chk($sformatf("t5_byte%0d", i), 32'(q0[base+i]), 32'(expq[i]));

        // Reset with 13 bits held, then a scan identical to the first one.
        send(0, 12, 'hABC, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_in_ready",   32'(if0.in_ready),   32'd0);
        chk("mid_rst_out_valid",  32'(if0.out_valid),  32'd0);
        chk("mid_rst_out_data",   if0.out_data,        32'h0);
        chk("mid_rst_out_nbytes", 32'(if0.out_nbytes), 32'd0);
        chk("mid_rst_out_last",   32'(if0.out_last),   32'd0);
        chk("mid_rst_byte_count", if0.byte_count,      32'd0);
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_ready_after", 32'(if0.in_ready), 32'd1);
        @(posedge clk); #1;
        w0   = words0;
        base = q0.size();
        send(0, 7, 'h7F, 1'b0);
        send(6, 0, 0, 1'b1);
        wait_last(6);
        chk("t6_data",   ld0,                  32'hFF010000);
        chk("t6_nb",     32'(ln0),             32'd2);
        chk("t6_bc",     lbc0,                 32'd2);
        chk("t6_words",  words0 - w0,          32'd1);
        chk("t6_nbytes", 32'(q0.size() - base), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
